// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 UART receiver that strobes good bytes into sequential frame-buffer addresses.
// Tracks a frame of FRAME_BYTES writes and flags completion until cleared.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rx,
  input  logic        clear,
  output logic [7:0]  data_out,
  output logic        Rx_ready,
  output logic        wr_en,
  output logic [15:0] W_address,
  output logic        framing_err,
  output logic        Rx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LAST = 16'(FRAME_BYTES - 1);
  state_t      r_state;
  logic        r_s1, r_rxs;
  logic [15:0] r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        w_tick, w_good, w_bad;
  assign w_tick = r_timer == FULL;
  assign w_good = r_state == STOP && w_tick && r_rxs;
  assign w_bad  = r_state == STOP && w_tick && !r_rxs;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s1        <= 1'b1;
      r_rxs       <= 1'b1;
      r_timer     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      data_out    <= '0;
      Rx_ready    <= 1'b0;
      wr_en       <= 1'b0;
      framing_err <= 1'b0;
      W_address   <= '0;
      Rx_done     <= 1'b0;
    end else begin
      r_s1        <= Rx;
      r_rxs       <= r_s1;
      Rx_ready    <= w_good;
      framing_err <= w_bad;
      wr_en       <= w_good && !Rx_done && !clear;
      if (w_good) data_out <= r_shift;
      // clear overrides the post-write address advance
      if (clear) begin
        W_address <= '0;
        Rx_done   <= 1'b0;
      end else if (wr_en) begin
        W_address <= W_address == LAST ? 16'd0 : W_address + 16'd1;
        if (W_address == LAST) Rx_done <= 1'b1;
      end
      case (r_state)
        IDLE: if (!r_rxs) begin
          r_state <= START;
          r_timer <= '0;
        end
        START: if (r_timer == HALF) begin
          r_timer <= '0;
          r_idx   <= '0;
          r_state <= r_rxs ? IDLE : DATA;
        end else r_timer <= r_timer + 16'd1;
        DATA: if (w_tick) begin
          r_timer        <= '0;
          r_shift[r_idx] <= r_rxs;
          r_idx          <= r_idx + 3'd1;
          if (r_idx == 3'd7) r_state <= STOP;
        end else r_timer <= r_timer + 16'd1;
        STOP: if (w_tick) begin
          r_timer <= '0;
          r_state <= r_rxs ? IDLE : WAIT_HIGH;
        end else r_timer <= r_timer + 16'd1;
        WAIT_HIGH: if (r_rxs) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed UART frames checked against an event-queue model of the receiver.
module tb_uart_frame_rx;
  localparam int CPB = 16;
  localparam int FB = 4;
  localparam int LAT = 155;
  logic clk = 0, rst = 1, rx = 1, clear = 0;
  logic [7:0] data_out;
  logic Rx_ready, wr_en, framing_err, Rx_done;
  logic [15:0] W_address;
  int checks = 0, failures = 0, cyc = 0, n_wr = 0, n_rdy = 0, n_fe = 0;
  bit q_good[$];
  logic [7:0] q_data[$];
  int q_due[$];
  logic [7:0] m_data = 0;
  int m_addr = 0;
  bit m_done = 0;

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB)) dut (
    .clk(clk), .rst(rst), .Rx(rx), .clear(clear), .data_out(data_out), .Rx_ready(Rx_ready),
    .wr_en(wr_en), .W_address(W_address), .framing_err(framing_err), .Rx_done(Rx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (wr_en) n_wr++;
    if (Rx_ready) n_rdy++;
    if (framing_err) n_fe++;
    if (rst) begin
      chk(data_out == 0 && !Rx_ready && !wr_en && !framing_err && W_address == 0 && !Rx_done,
          "reset_outputs", {data_out, W_address, Rx_ready, wr_en, framing_err, Rx_done}, 0);
      m_data = 0; m_addr = 0; m_done = 0;
      q_good.delete(); q_data.delete(); q_due.delete();
    end else begin
      chk(Rx_done == m_done, "rx_done", Rx_done, m_done);
      if (Rx_ready || framing_err) begin
        if (q_good.size() == 0) chk(0, "unexpected_pulse", {Rx_ready, framing_err}, 0);
        else begin
          bit g;
          logic [7:0] b;
          int due;
          g = q_good.pop_front(); b = q_data.pop_front(); due = q_due.pop_front();
          chk(cyc >= due - 2 && cyc <= due + 2, "pulse_timing", cyc, due);
          chk(Rx_ready == g && framing_err == !g, "pulse_kind", {Rx_ready, framing_err}, {g, !g});
          if (g) begin
            chk(data_out == b, "data_out_pulse", data_out, b);
            chk(wr_en == !m_done, "wr_en_pulse", wr_en, !m_done);
            chk(W_address == 16'(m_addr), "w_address_pulse", W_address, m_addr);
            m_data = b;
            if (!m_done) begin
              m_addr = (m_addr + 1) % FB;
              m_done = m_addr == 0;
            end
          end else begin
            chk(!wr_en, "wr_en_on_ferr", wr_en, 0);
            chk(data_out == m_data, "data_out_ferr", data_out, m_data);
          end
        end
      end else begin
        chk(!wr_en, "wr_en_idle", wr_en, 0);
        chk(data_out == m_data, "data_out", data_out, m_data);
        chk(W_address == 16'(m_addr), "w_address", W_address, m_addr);
      end
      if (q_due.size() != 0 && cyc > q_due[0] + 2) begin
        chk(0, "pulse_timeout", cyc, q_due[0]);
        void'(q_good.pop_front()); void'(q_data.pop_front()); void'(q_due.pop_front());
      end
      if (clear) begin
        m_addr = 0;
        m_done = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit stop);
    rx = 0;
    q_good.push_back(stop); q_data.push_back(b); q_due.push_back(cyc + LAT);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk(data_out == 0 && W_address == 0 && !Rx_done, "lit_reset", data_out, 0);
    rst = 0;
    idle(10);
    send(8'hA5, 1);
    idle(20);
    chk(data_out == 8'hA5, "lit_a5_data", data_out, 8'hA5);
    chk(W_address == 16'd1 && !Rx_done, "lit_a5_addr", W_address, 1);
    chk(n_wr == 1 && n_rdy == 1, "lit_a5_pulses", n_wr, 1);
    pulse_clear();
    idle(5);
    chk(W_address == 16'd0, "lit_clear_addr", W_address, 0);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 1);
    idle(20);
    chk(Rx_done && W_address == 16'd0, "lit_frame_done", {Rx_done, W_address}, {1'b1, 16'd0});
    chk(data_out == 8'h04 && n_wr == 5, "lit_frame_wr", n_wr, 5);
    send(8'h55, 1);
    idle(20);
    chk(data_out == 8'h55 && n_wr == 5 && n_rdy == 6, "lit_after_done", {data_out, 8'(n_wr)}, {8'h55, 8'd5});
    send(8'h3C, 0);
    repeat (40) @(negedge clk);
    idle(40);
    chk(n_fe == 1 && n_rdy == 6 && data_out == 8'h55, "lit_ferr", {8'(n_fe), data_out}, {8'd1, 8'h55});
    rx = 0;
    repeat (5) @(negedge clk);
    idle(40);
    chk(n_fe == 1 && n_rdy == 6, "lit_glitch", n_rdy, 6);
    rx = 0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    rx = 1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    idle(20);
    send(8'h7E, 1);
    idle(20);
    chk(data_out == 8'h7E && W_address == 16'd1 && !Rx_done, "lit_rst_recover", data_out, 8'h7E);
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    idle(20);
    chk(Rx_done == 1, "lit_done_again", Rx_done, 1);
    pulse_clear();
    idle(5);
    send(8'h99, 1);
    idle(20);
    chk(data_out == 8'h99 && W_address == 16'd1 && !Rx_done, "lit_clear_99", {data_out, W_address}, {8'h99, 16'd1});
    chk(q_good.size() == 0, "drain", q_good.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 Parameter FRAME_BYTES, default 65536, bytes per image frame; legal range 2..65536.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Rx  input  1  serial line, 8N1, LSB first, idle high; asynchronous to clk.
REQ-006 clear  input  1  synchronous, active-high; restarts frame bookkeeping.
REQ-007 data_out  output  8  last correctly framed byte; held until the next good byte.
REQ-008 Rx_ready  output  1  one-cycle pulse: data_out has just been updated.
REQ-009 wr_en  output  1  one-cycle memory write strobe for the current byte.
REQ-010 W_address  output  16  memory address for the byte qualified by wr_en.
REQ-011 framing_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 Rx_done  output  1  sticky: FRAME_BYTES bytes have been written.

Function
REQ-013 Rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; a single 16-bit bit-timer and a 3-bit bit index.
REQ-015 IDLE: when rxs=0 -> START, timer=0.
REQ-016 START: at timer=CLKS_PER_BIT/2-1, if rxs=0 -> DATA with timer=0 and index=0; if rxs=1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: at timer=CLKS_PER_BIT-1, shift rxs into bit[index] with timer reset; after index 7 -> STOP.
REQ-018 STOP: at timer=CLKS_PER_BIT-1, rxs=1 -> good byte, IDLE; rxs=0 -> framing_err pulse, byte discarded, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rxs=1, then -> IDLE; no start bit is accepted while in this state.
REQ-020 Good byte: on the cycle after the stop-bit sample, data_out updated and Rx_ready=1 for exactly one cycle.
REQ-021 wr_en SHALL pulse in the same cycle as Rx_ready, with W_address = index of that byte in the frame, only while Rx_done=0.
REQ-022 W_address SHALL increment by 1 in the cycle after each wr_en; after the wr_en at FRAME_BYTES-1, W_address=0 and Rx_done=1 in the next cycle.
REQ-023 While Rx_done=1, good bytes still update data_out and pulse Rx_ready; wr_en stays 0 and W_address stays 0.
REQ-024 clear=1 SHALL set W_address=0 and Rx_done=0 next cycle without disturbing the FSM or data_out.
REQ-025 If clear coincides with a good byte, clear wins: no wr_en, W_address=0.
REQ-026 Byte-to-byte back-to-back frames (start immediately after stop) SHALL be received without loss.

Reset
REQ-027 rst=1 SHALL immediately force: FSM=IDLE, synchronizer flops=1, timer=0, index=0, data_out=0, Rx_ready=0, wr_en=0, framing_err=0, W_address=0, Rx_done=0.
REQ-028 A reset during a byte SHALL abandon the byte; after release, reception restarts from the next falling edge of rxs.

Verification (CLKS_PER_BIT=16, FRAME_BYTES=4)
REQ-029 Send 0xA5 after reset -> Rx_ready and wr_en one-cycle pulses, data_out=0xA5, W_address=0 during the pulse, then W_address=1.
REQ-030 Send 0x01,0x02,0x03,0x04 back-to-back -> four wr_en pulses at addresses 0..3, Rx_done=1, W_address=0; a fifth byte 0x55 -> Rx_ready pulse, data_out=0x55, no wr_en.
REQ-031 Send 0x3C with stop bit low, then hold Rx low for 40 cycles -> one framing_err pulse, no Rx_ready, no restart until Rx goes high; data_out unchanged.
REQ-032 Send a 5-cycle low glitch on idle Rx -> no Rx_ready, no framing_err, FSM back in IDLE.
REQ-033 Assert rst mid-byte (during bit 4), release, send 0x7E -> outputs zero during reset; then data_out=0x7E at W_address=0.
REQ-034 After Rx_done=1, pulse clear, send 0x99 -> Rx_done=0, wr_en at W_address=0, data_out=0x99.
